// File: rtl/dl_pkg.sv
// Shared constants and receiver state encoding for the downlink frame receiver.
// The bit period is truncated, so 10 MHz / 115200 gives 86 clocks per bit.
package dl_pkg;

  localparam int unsigned SYS_CLK_HZ   = 10_000_000;
  localparam int unsigned DEFAULT_BAUD = 115_200;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  localparam int unsigned DEFAULT_CLKS_PER_BIT = clks_per_bit(SYS_CLK_HZ, DEFAULT_BAUD);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/dl_frame_rx_if.sv
// Serial input and byte/frame result bundle of the downlink frame receiver.
// The master side is the receiver, and the slave side is whoever feeds rxd and consumes results.
interface dl_frame_rx_if #(
  parameter int DATASIZE = 128
);

  logic                rxd;
  logic [7:0]          rx_byte;
  logic                rx_byte_valid;
  logic [DATASIZE-1:0] frame_data;
  logic                frame_valid;
  logic                framing_err;
  logic                timeout_err;
  logic                busy;

  modport master (
    input  rxd,
    output rx_byte, rx_byte_valid, frame_data, frame_valid, framing_err, timeout_err, busy
  );

  modport slave (
    output rxd,
    input  rx_byte, rx_byte_valid, frame_data, frame_valid, framing_err, timeout_err, busy
  );

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver with a two-flop input synchronizer and start-bit glitch rejection.
// Data bits are sampled at the bit centres, which are timed from the start-bit midpoint.
module uart_rx
  import dl_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk10m,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       framing_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_reg;
  logic             prev_reg;
  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       byte_reg, byte_next;
  logic             valid_reg, valid_next;
  logic             ferr_reg, ferr_next;
  logic             rxd_s;

  assign rxd_s = sync_reg[1];

  always_ff @(posedge clk10m or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= 2'b11;
      prev_reg  <= 1'b1;
      state_reg <= RX_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      byte_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], rxd};
      prev_reg  <= rxd_s;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      byte_reg  <= byte_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    byte_next  = byte_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        cnt_next = '0;
        // Only a high-to-low transition starts a byte, so a stuck-low line stays idle.
        if (!rxd_s && prev_reg) state_next = RX_START;
      end
      RX_START: begin
        if (cnt_reg == HALF_CNT) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rxd_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next            = '0;
          shift_next[bit_reg] = rxd_s;
          bit_next            = bit_reg + 1'b1;
          if (bit_reg == 3'd7) state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          state_next = RX_IDLE;
          if (rxd_s) begin
            byte_next  = shift_reg;
            valid_next = 1'b1;
          end else begin
            ferr_next = 1'b1;
          end
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign rx_byte       = byte_reg;
  assign rx_byte_valid = valid_reg;
  assign framing_err   = ferr_reg;
  assign busy          = (state_reg != RX_IDLE);

endmodule

// File: rtl/dl_frame_rx.sv
// Downlink frame receiver. It packs NBYTES consecutive UART bytes into one frame word.
// A partial frame is dropped on an inter-byte timeout or on a framing error.
module dl_frame_rx
  import dl_pkg::*;
#(
  parameter int DATASIZE     = 128,
  parameter int NBYTES       = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input logic            clk10m,
  input logic            rst_n,
  dl_frame_rx_if.master  bus
);

  localparam int FW    = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int GAP_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CLKS - 1);

  if (NBYTES < 1 || NBYTES > DATASIZE / 8) begin : g_bad_param
    $error("dl_frame_rx: NBYTES out of range");
  end

  logic [7:0]       rx_byte_w;
  logic             rx_valid_w, ferr_w, rx_busy_w;
  logic [IDX_W-1:0] idx_reg;
  logic [FW-1:0]    shadow_reg, frame_reg;
  logic [GAP_W-1:0] gap_reg;
  logic             fv_reg, to_reg;
  wire  [FW-1:0]    merged;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk10m        (clk10m),
    .rst_n         (rst_n),
    .rxd           (bus.rxd),
    .rx_byte       (rx_byte_w),
    .rx_byte_valid (rx_valid_w),
    .framing_err   (ferr_w),
    .busy          (rx_busy_w)
  );

  // This is the shadow word with the incoming byte placed in lane idx.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign merged[8*gi +: 8] = (idx_reg == IDX_W'(gi)) ? rx_byte_w : shadow_reg[8*gi +: 8];
  end

  always_ff @(posedge clk10m or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg    <= '0;
      shadow_reg <= '0;
      frame_reg  <= '0;
      gap_reg    <= '0;
      fv_reg     <= 1'b0;
      to_reg     <= 1'b0;
    end else begin
      fv_reg <= 1'b0;
      to_reg <= 1'b0;
      // A received byte takes priority over a timeout that expires in the same cycle.
      if (rx_valid_w) begin
        gap_reg <= '0;
        if (idx_reg == LAST_IDX) begin
          frame_reg  <= merged;
          fv_reg     <= 1'b1;
          idx_reg    <= '0;
          shadow_reg <= '0;
        end else begin
          shadow_reg <= merged;
          idx_reg    <= idx_reg + 1'b1;
        end
      end else if (idx_reg != '0) begin
        if (ferr_w) begin
          idx_reg    <= '0;
          shadow_reg <= '0;
          gap_reg    <= '0;
        end else if (gap_reg == GAP_LAST) begin
          idx_reg    <= '0;
          shadow_reg <= '0;
          gap_reg    <= '0;
          to_reg     <= 1'b1;
        end else begin
          gap_reg <= gap_reg + 1'b1;
        end
      end else begin
        gap_reg <= '0;
      end
    end
  end

  assign bus.rx_byte       = rx_byte_w;
  assign bus.rx_byte_valid = rx_valid_w;
  assign bus.framing_err   = ferr_w;
  assign bus.frame_data    = DATASIZE'(frame_reg);
  assign bus.frame_valid   = fv_reg;
  assign bus.timeout_err   = to_reg;
  assign bus.busy          = rx_busy_w | (idx_reg != '0);

endmodule

// File: doc/dl_frame_rx.md
DL_FRAME_RX -- requirements
Module: dl_frame_rx

Interface
REQ-001 Parameter DATASIZE, default 128: width of the reassembled sample word.
REQ-002 Parameter NBYTES, default 8: bytes per frame; SHALL satisfy 1 <= NBYTES <= DATASIZE/8.
REQ-003 Parameter CLKS_PER_BIT, default 86 (10 MHz / 115200): clocks per UART bit.
REQ-004 Parameter TIMEOUT_CLKS, default 20*CLKS_PER_BIT: maximum idle gap between bytes of one frame.
REQ-005 clk10m  in  1  10 MHz clock; the only clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 rxd  in  1  UART serial input, 8N1, LSB first, idle high, asynchronous to clk10m.
REQ-008 rx_byte  out  8  last correctly received byte.
REQ-009 rx_byte_valid  out  1  one-cycle pulse; rx_byte is new.
REQ-010 frame_data  out  DATASIZE  last complete frame; byte k at bits [8k+7:8k].
REQ-011 frame_valid  out  1  one-cycle pulse; frame_data is new.
REQ-012 framing_err  out  1  one-cycle pulse; stop bit sampled low.
REQ-013 timeout_err  out  1  one-cycle pulse; partial frame discarded on timeout.
REQ-014 busy  out  1  high while the receiver FSM is not IDLE or a partial frame is held.

Function
REQ-015 rxd SHALL pass through a two-flop synchronizer; only the synchronized value is used.
REQ-016 Receiver FSM states: IDLE, START, DATA, STOP; one bit counter (0..CLKS_PER_BIT-1) and one bit index (0..7).
REQ-017 IDLE -> START when synchronized rxd is 0 and was 1 on the previous cycle (falling edge only; a held-low line never starts a byte).
REQ-018 START: at count (CLKS_PER_BIT-1)/2 (42 at default) sample rxd; 0 -> DATA with counter cleared; 1 -> IDLE, no output (glitch rejection).
REQ-019 DATA: sample every CLKS_PER_BIT clocks from the start-bit midpoint; bit i stored to position i; after bit 7 -> STOP.
REQ-020 STOP: sample after CLKS_PER_BIT clocks; 1 -> rx_byte updated and rx_byte_valid pulsed in the same cycle; 0 -> framing_err pulsed, rx_byte unchanged; both cases -> IDLE.
REQ-021 Latency: rx_byte_valid asserts 2 sync cycles + 9*CLKS_PER_BIT + (CLKS_PER_BIT-1)/2 clocks (±1) after the start-bit falling edge on rxd.
REQ-022 Assembler holds byte index idx (0..NBYTES-1) and a DATASIZE-bit shadow word; on rx_byte_valid the byte is written to shadow lane idx and idx increments.
REQ-023 When the byte written is at idx = NBYTES-1: frame_data <= shadow with that byte merged, frame_valid pulses exactly 1 cycle after rx_byte_valid, idx wraps to 0, shadow clears.
REQ-024 Lanes >= NBYTES in frame_data SHALL be 0.
REQ-025 frame_data holds its value between frame_valid pulses; partial frames never alter it.
REQ-026 Gap counter clears on every rx_byte_valid, counts while idx != 0, saturates; reaching TIMEOUT_CLKS -> idx = 0, shadow cleared, timeout_err pulse once.
REQ-027 framing_err with idx != 0 SHALL also discard the partial frame (idx = 0, shadow cleared); no timeout_err for the same event.
REQ-028 Simultaneous timeout expiry and rx_byte_valid: the byte wins; counter clears, no timeout_err.
REQ-029 No flow control: a new frame begins immediately after frame_valid; frame_valid is never suppressed.

Reset
REQ-030 On rst_n low: FSM IDLE, counters 0, idx 0, shadow 0, synchronizer flops 1, rx_byte 0, frame_data 0, all pulse outputs 0, busy 0.
REQ-031 Reset asserted mid-byte or mid-frame SHALL discard all partial state; after release the first valid start-bit edge is received normally.

Structure
REQ-032 Shared package dl_pkg SHALL hold the system clock frequency, default baud, CLKS_PER_BIT derivation, and receiver FSM state encoding.
REQ-033 Byte reception (synchronizer, FSM, REQ-015..021) SHALL be a sub-module uart_rx; dl_frame_rx instantiates it and owns the assembler and timeout logic.

Verification
REQ-034 Send 8 bytes 0x45,0x23,0x01,0xAA,0x45,0x23,0x01,0xAA at 115200 -> eight rx_byte_valid, one frame_valid, frame_data[63:0] = 64'hAA01_2345_AA01_2345, bits [127:64] = 0.
REQ-035 Byte 0x55 with stop bit forced low -> framing_err pulse, no rx_byte_valid, rx_byte unchanged.
REQ-036 1 µs (10-clock) low glitch on idle rxd -> no output pulses, FSM returns to IDLE.
REQ-037 Send 3 bytes, idle 25 bit times, then 8 bytes 0x00..0x07 -> one timeout_err, then frame_valid with frame_data[63:0] = 64'h0706_0504_0302_0100.
REQ-038 rst_n pulsed low during byte 5 of a frame, then a full 8-byte frame -> frame_data 0 after reset, exactly one frame_valid carrying only the new frame.
REQ-039 Baud skew ±2% on all bytes of REQ-034 -> identical result, no errors.
